rs_syndrome_calc: RTL and testbench

- Receive-side stage that consumes the 60-bit codeword produced by encodingCont: RS(15,9) over GF(2^4), 4-bit symbols, t=3.
- Evaluates the six syndromes S1..S6 serially, one codeword symbol per clock, using Horner's rule.
- Sits directly downstream of encodingCont and upstream of the future key-equation/Chien error-correction stage.
- Non-zero syndromes flag a corrupted codeword.

---
 rtl/rs_syndrome_calc.sv | 108 ++++++++++
 tb/tb_rs_syndrome_calc.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rs_syndrome_calc.sv
// Serial RS(15,9) syndrome calculator over GF(16): evaluates S1..S6 of a
// received codeword with Horner's rule, one symbol per clock, highest symbol first.
module rs_syndrome_calc #(
   parameter int SYM_W = 4,
   parameter int N     = 15,
   parameter int NSYM  = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    startDecode,
   input  logic [SYM_W*N-1:0]      codeWordVector,
   output logic                    decoderBusy,
   output logic                    syndromeValid,
   output logic [SYM_W*NSYM-1:0]   syndromes,
   output logic                    errorDetected
);

   localparam int CNT_W = $clog2(N);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                          state;
   state_t                          state_next;
   logic [CNT_W-1:0]                count;
   logic [SYM_W*N-1:0]              cw_reg;
   logic [NSYM-1:0][SYM_W-1:0]      acc;
   logic [NSYM-1:0][SYM_W-1:0]      acc_next;
   logic [SYM_W-1:0]                cur_sym;
   logic [SYM_W*NSYM-1:0]           result;
   logic                            err;

   // Multiply by alpha modulo x^4+x+1: shift left, fold x^4 back in as x+1.
   function automatic logic [SYM_W-1:0] mul_alpha(input logic [SYM_W-1:0] x);
      return {x[2:0], 1'b0} ^ {2'b00, x[3], x[3]};
   endfunction

   // Constant power of alpha, unrolled into a fixed XOR network for each j.
   function automatic logic [SYM_W-1:0] mul_alpha_pow(input logic [SYM_W-1:0] x,
                                                      input int j);
      logic [SYM_W-1:0] r;
      r = x;
      for (int k = 0; k < j; k++) r = mul_alpha(r);
      return r;
   endfunction

   assign cur_sym = cw_reg[int'(count)*SYM_W +: SYM_W];

   always_comb begin
      for (int j = 0; j < NSYM; j++) begin
         acc_next[j] = mul_alpha_pow(acc[j], j + 1) ^ cur_sym;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (startDecode) state_next = RUN;
         RUN:     if (count == '0) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         count  <= '0;
         cw_reg <= '0;
         acc    <= '0;
         result <= '0;
         err    <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (startDecode) begin
                  cw_reg <= codeWordVector;
                  acc    <= '0;
                  count  <= CNT_W'(N - 1);
                  result <= '0;
                  err    <= 1'b0;
               end
            end
            RUN: begin
               acc <= acc_next;
               // Publish on the last Horner step so results are ready in DONE.
               if (count == '0) begin
                  result <= acc_next;
                  err    <= |acc_next;
               end else begin
                  count <= count - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign decoderBusy   = (state == RUN);
   assign syndromeValid = (state == DONE);
   assign syndromes     = result;
   assign errorDetected = err;

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Bench for rs_syndrome_calc: syndromes are checked against a direct
// polynomial-evaluation model and a systematic RS(15,9) encoder in GF(16).
module tb_rs_syndrome_calc;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [59:0] cw_in;
   logic        busy;
   logic        valid;
   logic [23:0] syndromes;
   logic        err;

   int n_checks = 0;
   int n_fail   = 0;

   rs_syndrome_calc #(.SYM_W(4), .N(15), .NSYM(6)) dut (
      .clk            (clk),
      .rst            (rst),
      .startDecode    (start),
      .codeWordVector (cw_in),
      .decoderBusy    (busy),
      .syndromeValid  (valid),
      .syndromes      (syndromes),
      .errorDetected  (err)
   );

   always #10 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
      int p;
      p = 0;
      for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (int'(a) << i);
      for (int k = 6; k >= 4; k--) if (p[k]) p = p ^ (32'h13 << (k - 4));
      return p[3:0];
   endfunction

   function automatic logic [3:0] gf_pow(input logic [3:0] a, input int e);
      logic [3:0] r;
      r = 4'h1;
      for (int i = 0; i < e; i++) r = gf_mul(r, a);
      return r;
   endfunction

   function automatic logic [23:0] syn_model(input logic [59:0] cw);
      logic [23:0] s;
      logic [3:0]  acc;
      s = '0;
      for (int j = 1; j <= 6; j++) begin
         acc = 4'h0;
         for (int i = 0; i < 15; i++) acc = acc ^ gf_mul(cw[4*i +: 4], gf_pow(4'h2, i * j));
         s[4*j-4 +: 4] = acc;
      end
      return s;
   endfunction

   function automatic logic [59:0] rs_encode(input logic [35:0] msg);
      logic [3:0]  g [7];
      logic [3:0]  gn [7];
      logic [3:0]  rem [6];
      logic [3:0]  fb;
      logic [59:0] cw;
      for (int t = 0; t < 7; t++) g[t] = 4'h0;
      g[0] = 4'h1;
      for (int j = 1; j <= 6; j++) begin
         for (int t = 0; t < 7; t++)
            gn[t] = gf_mul(g[t], gf_pow(4'h2, j)) ^ ((t > 0) ? g[t-1] : 4'h0);
         for (int t = 0; t < 7; t++) g[t] = gn[t];
      end
      for (int t = 0; t < 6; t++) rem[t] = 4'h0;
      for (int k = 8; k >= 0; k--) begin
         fb = msg[4*k +: 4] ^ rem[5];
         for (int t = 5; t >= 1; t--) rem[t] = rem[t-1] ^ gf_mul(fb, g[t]);
         rem[0] = gf_mul(fb, g[0]);
      end
      cw = '0;
      cw[59:24] = msg;
      for (int t = 0; t < 6; t++) cw[4*t +: 4] = rem[t];
      return cw;
   endfunction

   // ---------------- driver / monitor ----------------
   task automatic do_reset();
      rst = 1'b1; start = 1'b0; cw_in = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   // Called at a negedge. Sample k observes the cycle after start edge + k.
   task automatic run_one(input logic [59:0] cw, input bit disturb,
                          output logic [23:0] syn_v, output logic err_v,
                          output logic [23:0] syn_h, output int busy_cnt,
                          output int valid_k, output int valid_cnt, output bit run_clear);
      busy_cnt = 0; valid_k = -1; valid_cnt = 0; run_clear = 1'b1;
      syn_v = '0; err_v = 1'b0; syn_h = '0;
      cw_in = cw; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 25; k++) begin
         if (busy) busy_cnt++;
         if (valid) begin
            valid_cnt++;
            if (valid_k < 0) begin valid_k = k; syn_v = syndromes; err_v = err; end
         end
         if (k <= 14 && (syndromes !== 24'h0 || err !== 1'b0)) run_clear = 1'b0;
         if (k == 20) syn_h = syndromes;
         if (disturb) begin
            if (k == 3 || k == 15) begin start = 1'b1; cw_in = 60'({$urandom(), $urandom()}); end
            else if (k == 4 || k == 16) start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
      n_checks++; if (syndromes !== 24'h0) begin n_fail++; $display("FAIL reset_syn got %h want 000000", syndromes); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
   endtask

   task automatic test_vector(input string name, input logic [59:0] cw,
                              input logic [23:0] exp_const, input bit use_const, input bit disturb);
      logic [23:0] syn_v, syn_h, exp_syn;
      logic        err_v;
      int          busy_cnt, valid_k, valid_cnt;
      bit          run_clear;
      exp_syn = syn_model(cw);
      run_one(cw, disturb, syn_v, err_v, syn_h, busy_cnt, valid_k, valid_cnt, run_clear);
      if (use_const) begin
         n_checks++; if (syn_v !== exp_const) begin n_fail++; $display("FAIL %s_const got %h want %h", name, syn_v, exp_const); end
      end
      n_checks++; if (syn_v !== exp_syn) begin n_fail++; $display("FAIL %s_syn got %h want %h", name, syn_v, exp_syn); end
      n_checks++; if (err_v !== (exp_syn != 24'h0)) begin n_fail++; $display("FAIL %s_err got %b want %b", name, err_v, exp_syn != 24'h0); end
      n_checks++; if (busy_cnt != 15) begin n_fail++; $display("FAIL %s_busy_cycles got %0d want 15", name, busy_cnt); end
      n_checks++; if (valid_k != 15) begin n_fail++; $display("FAIL %s_valid_time got %0d want 15", name, valid_k); end
      n_checks++; if (valid_cnt != 1) begin n_fail++; $display("FAIL %s_valid_pulses got %0d want 1", name, valid_cnt); end
      n_checks++; if (run_clear !== 1'b1) begin n_fail++; $display("FAIL %s_cleared_in_run got %b want 1", name, run_clear); end
      n_checks++; if (syn_h !== exp_syn) begin n_fail++; $display("FAIL %s_hold got %h want %h", name, syn_h, exp_syn); end
   endtask

   task automatic test_random();
      logic [59:0] cw;
      for (int n = 0; n < 6; n++) begin
         if (n[0]) cw = rs_encode(36'({$urandom(), $urandom()}))
                        ^ (60'h1 << $urandom_range(59, 0));
         else      cw = 60'({$urandom(), $urandom()});
         test_vector($sformatf("random%0d", n), cw, 24'h0, 1'b0, 1'b0);
      end
   endtask

   task automatic test_loopback();
      logic [59:0] cw;
      cw = rs_encode(36'h0000000E0);
      test_vector("loopback", cw, 24'h000000, 1'b1, 1'b0);
      cw[30] = ~cw[30];
      test_vector("loopback_flip", cw, 24'h0, 1'b0, 1'b0);
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL loopback_flip_err_hold got %b want 1", err); end
   endtask

   task automatic test_reset_mid();
      int valid_cnt, busy_cnt;
      cw_in = 60'h123456789ABCDEF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 6; k++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b want 0", valid); end
      n_checks++; if (syndromes !== 24'h0) begin n_fail++; $display("FAIL rstmid_syn got %h want 000000", syndromes); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rstmid_err got %b want 0", err); end
      rst = 1'b0;
      valid_cnt = 0; busy_cnt = 0;
      for (int k = 0; k < 25; k++) begin
         if (valid) valid_cnt++;
         if (busy) busy_cnt++;
         @(negedge clk);
      end
      n_checks++; if (valid_cnt != 0) begin n_fail++; $display("FAIL rstmid_no_valid got %0d want 0", valid_cnt); end
      n_checks++; if (busy_cnt != 0) begin n_fail++; $display("FAIL rstmid_no_busy got %0d want 0", busy_cnt); end
      test_vector("after_reset", 60'h10, 24'hC63842, 1'b1, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [59:0]  cw;
      logic [23:0]  exp_syn;
      int           vk[$];
      logic [23:0]  vs[$];
      cw = 60'({$urandom(), $urandom()});
      exp_syn = syn_model(cw);
      cw_in = cw; start = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 60; k++) begin
         if (valid) begin vk.push_back(k); vs.push_back(syndromes); end
         @(negedge clk);
      end
      start = 1'b0;
      repeat (20) @(negedge clk);
      n_checks++; if (vk.size() != 3) begin n_fail++; $display("FAIL b2b_count got %0d want 3", vk.size()); end
      for (int i = 0; i < vk.size(); i++) begin
         n_checks++; if (vk[i] != 15 + 17 * i) begin n_fail++; $display("FAIL b2b_time%0d got %0d want %0d", i, vk[i], 15 + 17 * i); end
         n_checks++; if (vs[i] !== exp_syn) begin n_fail++; $display("FAIL b2b_syn%0d got %h want %h", i, vs[i], exp_syn); end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; cw_in = '0;
      test_reset();
      test_vector("zero", 60'h0, 24'h000000, 1'b1, 1'b0);
      test_vector("c0", 60'h1, 24'h111111, 1'b1, 1'b0);
      test_vector("c1", 60'h10, 24'hC63842, 1'b1, 1'b0);
      test_loopback();
      test_random();
      test_vector("disturb", 60'hFEDCBA987654321, 24'h0, 1'b0, 1'b1);
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
